mem1: RTL and testbench



---
 rtl/mem1_pkg.sv | 18 +
 rtl/mem1_memlane.sv | 28 ++
 rtl/mem1.sv | 116 +++++++++++
 tb/tb_mem1.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem1_pkg.sv
// mem1_pkg: shared types, access-size encodings and FSM states for the memory stage
package mem1_pkg;

    typedef logic [31:0] data_t;
    typedef logic [4:0]  reg_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    // size 2'b11 falls through to the word rule
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_HALF) ? a[0] : (size == SZ_BYTE) ? 1'b0 : (a != 2'b00);
    endfunction

endpackage

// File: rtl/mem1_memlane.sv
// mem1_memlane: store lane replication / byte enables and load lane extraction / extension
module mem1_memlane
    import mem1_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr,
    input  logic       i_sign,
    input  data_t      i_sdata,
    input  data_t      i_rdata,
    output logic [3:0] o_be,
    output data_t      o_wdata,
    output data_t      o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte  = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    assign o_be    = (i_size == SZ_HALF) ? (i_addr[1] ? 4'b1100 : 4'b0011) :
                     (i_size == SZ_BYTE) ? (4'b0001 << i_addr) : 4'b1111;
    assign o_wdata = (i_size == SZ_HALF) ? {2{i_sdata[15:0]}} :
                     (i_size == SZ_BYTE) ? {4{i_sdata[7:0]}} : i_sdata;
    assign o_ldata = (i_size == SZ_HALF) ? {{16{i_sign & w_half[15]}}, w_half} :
                     (i_size == SZ_BYTE) ? {{24{i_sign & w_byte[7]}}, w_byte} : i_rdata;

endmodule

// File: rtl/mem1.sv
// mem1: EX/MEM register, ready-handshake data-memory access and MEM/WB register
module mem1
    import mem1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_invalid,
    input  data_t       MEM_inanswer,
    input  data_t       MEM_instoredata,
    input  reg_t        MEM_inregdst,
    input  logic        MEM_inandlink,
    input  data_t       MEM_inpc8,
    input  logic        MEM_inregwrite,
    input  logic        MEM_inmemread,
    input  logic        MEM_inmemwrite,
    input  logic [1:0]  MEM_inmemsize,
    input  logic        MEM_inmemsign,
    output logic        MEM_outdreq,
    output logic        MEM_outdwe,
    output data_t       MEM_outdaddr,
    output data_t       MEM_outdwdata,
    output logic [3:0]  MEM_outdbe,
    input  logic        MEM_indready,
    input  data_t       MEM_indrdata,
    output logic        MEM_outstall,
    output logic        MEM_outmisalign,
    output reg_t        MEM_outEXMEMREGISTERRDRT,
    output logic        MEM_outEXMEMREGWRITE,
    output data_t       MEM_outfromEXMEM,
    output reg_t        MEM_outMEMWBREGISTERRDRT,
    output logic        MEM_outMEMWBREGWRITE,
    output data_t       MEM_outfromMEMWB
);

    logic       r_valid, r_andlink, r_regwrite, r_memread, r_memwrite, r_memsign;
    data_t      r_answer, r_storedata, r_pc8;
    reg_t       r_regdst;
    logic [1:0] r_memsize;
    state_e     r_state;
    reg_t       r_wb_regdst;
    logic       r_wb_regwrite;
    data_t      r_wb_data;

    logic       w_memop, w_mis, w_pending, w_stall;
    data_t      w_ldata;

    assign w_memop   = r_valid & (r_memread | r_memwrite);
    assign w_mis     = w_memop & misaligned(r_memsize, r_answer[1:0]);
    assign w_pending = w_memop & ~w_mis;
    assign w_stall   = w_pending & ~MEM_indready;

    mem1_memlane u_memlane (
        .i_size  (r_memsize),
        .i_addr  (r_answer[1:0]),
        .i_sign  (r_memsign),
        .i_sdata (r_storedata),
        .i_rdata (MEM_indrdata),
        .o_be    (MEM_outdbe),
        .o_wdata (MEM_outdwdata),
        .o_ldata (w_ldata)
    );

    // WAIT only ever holds the op that is still pending, so this equals w_pending
    assign MEM_outdreq              = w_pending | (r_state == S_WAIT);
    assign MEM_outdwe               = w_pending & r_memwrite;
    assign MEM_outdaddr             = {r_answer[31:2], 2'b00};
    assign MEM_outstall             = w_stall;
    assign MEM_outmisalign          = w_mis;
    assign MEM_outEXMEMREGISTERRDRT = r_regdst;
    assign MEM_outEXMEMREGWRITE     = r_regwrite & ~w_mis;
    assign MEM_outfromEXMEM         = r_andlink ? r_pc8 : r_answer;
    assign MEM_outMEMWBREGISTERRDRT = r_wb_regdst;
    assign MEM_outMEMWBREGWRITE     = r_wb_regwrite;
    assign MEM_outfromMEMWB         = r_wb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_answer      <= '0;
            r_storedata   <= '0;
            r_regdst      <= '0;
            r_andlink     <= 1'b0;
            r_pc8         <= '0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_memsize     <= SZ_WORD;
            r_memsign     <= 1'b0;
            r_state       <= S_IDLE;
            r_wb_regdst   <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= '0;
        end else begin
            r_state <= w_stall ? S_WAIT : S_IDLE;
            if (w_stall) begin
                r_wb_regwrite <= 1'b0;
            end else begin
                r_valid       <= MEM_invalid;
                r_answer      <= MEM_inanswer;
                r_storedata   <= MEM_instoredata;
                r_regdst      <= MEM_inregdst;
                r_andlink     <= MEM_inandlink;
                r_pc8         <= MEM_inpc8;
                r_regwrite    <= MEM_inregwrite & MEM_invalid & (MEM_inregdst != 5'd0);
                r_memread     <= MEM_inmemread;
                r_memwrite    <= MEM_inmemwrite;
                r_memsize     <= MEM_inmemsize;
                r_memsign     <= MEM_inmemsign;
                r_wb_regdst   <= r_regdst;
                r_wb_regwrite <= r_regwrite & ~w_mis;
                r_wb_data     <= r_andlink ? r_pc8 : r_memread ? w_ldata : r_answer;
            end
        end
    end

endmodule

// File: tb/tb_mem1.sv
// tb_mem1: table vectors, randomized ops against a byte-level reference model, and stall/reset sequences
module tb_mem1;

    logic        clk, reset;
    logic        MEM_invalid, MEM_inandlink, MEM_inregwrite, MEM_inmemread, MEM_inmemwrite, MEM_inmemsign;
    logic [31:0] MEM_inanswer, MEM_instoredata, MEM_inpc8;
    logic [4:0]  MEM_inregdst;
    logic [1:0]  MEM_inmemsize;
    logic        MEM_outdreq, MEM_outdwe, MEM_indready, MEM_outstall, MEM_outmisalign;
    logic [31:0] MEM_outdaddr, MEM_outdwdata, MEM_indrdata;
    logic [3:0]  MEM_outdbe;
    logic [4:0]  MEM_outEXMEMREGISTERRDRT, MEM_outMEMWBREGISTERRDRT;
    logic        MEM_outEXMEMREGWRITE, MEM_outMEMWBREGWRITE;
    logic [31:0] MEM_outfromEXMEM, MEM_outfromMEMWB;

    mem1 dut (
        .clk(clk), .reset(reset),
        .MEM_invalid(MEM_invalid), .MEM_inanswer(MEM_inanswer), .MEM_instoredata(MEM_instoredata),
        .MEM_inregdst(MEM_inregdst), .MEM_inandlink(MEM_inandlink), .MEM_inpc8(MEM_inpc8),
        .MEM_inregwrite(MEM_inregwrite), .MEM_inmemread(MEM_inmemread), .MEM_inmemwrite(MEM_inmemwrite),
        .MEM_inmemsize(MEM_inmemsize), .MEM_inmemsign(MEM_inmemsign),
        .MEM_outdreq(MEM_outdreq), .MEM_outdwe(MEM_outdwe), .MEM_outdaddr(MEM_outdaddr),
        .MEM_outdwdata(MEM_outdwdata), .MEM_outdbe(MEM_outdbe),
        .MEM_indready(MEM_indready), .MEM_indrdata(MEM_indrdata),
        .MEM_outstall(MEM_outstall), .MEM_outmisalign(MEM_outmisalign),
        .MEM_outEXMEMREGISTERRDRT(MEM_outEXMEMREGISTERRDRT), .MEM_outEXMEMREGWRITE(MEM_outEXMEMREGWRITE),
        .MEM_outfromEXMEM(MEM_outfromEXMEM),
        .MEM_outMEMWBREGISTERRDRT(MEM_outMEMWBREGISTERRDRT), .MEM_outMEMWBREGWRITE(MEM_outMEMWBREGWRITE),
        .MEM_outfromMEMWB(MEM_outfromMEMWB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] answer, sdata, pc8;
        logic [4:0]  regdst;
        logic        andlink, regwrite, memread, memwrite;
        logic [1:0]  size;
        logic        sign;
        int          waitn;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic        fwd_rw;
        logic [31:0] fwd_data;
        logic        req, we, mis;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        logic        wb_rw;
        logic [31:0] wb_data;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input op_t o);
        MEM_invalid     = o.valid;
        MEM_inanswer    = o.answer;
        MEM_instoredata = o.sdata;
        MEM_inpc8       = o.pc8;
        MEM_inregdst    = o.regdst;
        MEM_inandlink   = o.andlink;
        MEM_inregwrite  = o.regwrite;
        MEM_inmemread   = o.memread;
        MEM_inmemwrite  = o.memwrite;
        MEM_inmemsize   = o.size;
        MEM_inmemsign   = o.sign;
    endtask

    function automatic op_t bubble();
        op_t o;
        o = '{1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0};
        return o;
    endfunction

    // Reference: an access touches n bytes starting at byte offset off of the addressed word
    function automatic exp_t model(input op_t o);
        exp_t        e;
        int          n, off;
        logic [31:0] mask, ld;
        n    = (o.size == 2'b01) ? 2 : (o.size == 2'b10) ? 1 : 4;
        off  = int'(o.answer[1:0]);
        e.mis      = o.valid & (o.memread | o.memwrite) & ((off % n) != 0);
        e.req      = o.valid & (o.memread | o.memwrite) & ((off % n) == 0);
        e.we       = e.req & o.memwrite;
        e.addr     = o.answer - 32'(off);
        e.fwd_data = o.andlink ? o.pc8 : o.answer;
        e.fwd_rw   = o.valid & o.regwrite & (o.regdst != 5'd0) & ~e.mis;
        e.be       = 4'b0000;
        e.wdata    = 32'h0;
        for (int k = 0; k < 4; k++) begin
            e.be[k]          = (k >= off) && (k < off + n);
            e.wdata[8*k +: 8] = o.sdata[8*(k % n) +: 8];
        end
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        ld   = (o.rdata >> (8 * off)) & mask;
        if (o.sign && n < 4 && ld[8*n-1]) ld = ld | ~mask;
        e.wb_rw   = e.fwd_rw;
        e.wb_data = o.andlink ? o.pc8 : o.memread ? ld : o.answer;
        return e;
    endfunction

    task automatic apply(input op_t o, input exp_t e);
        @(negedge clk);
        drive(o);
        MEM_indready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        drive(bubble());
        MEM_indready = 1'b0;
        #1;
        chk("exmem_rd", 32'(MEM_outEXMEMREGISTERRDRT), 32'(o.regdst));
        chk("exmem_rw", 32'(MEM_outEXMEMREGWRITE), 32'(e.fwd_rw));
        chk("exmem_data", MEM_outfromEXMEM, e.fwd_data);
        chk("dreq", 32'(MEM_outdreq), 32'(e.req));
        chk("misalign", 32'(MEM_outmisalign), 32'(e.mis));
        if (e.req) begin
            chk("daddr", MEM_outdaddr, e.addr);
            chk("dwe", 32'(MEM_outdwe), 32'(e.we));
        end
        if (e.we) begin
            chk("dbe", 32'(MEM_outdbe), 32'(e.be));
            chk("dwdata", MEM_outdwdata, e.wdata);
        end
        if (e.req) begin
            for (int i = 0; i < o.waitn; i++) begin
                chk("stall_wait", 32'(MEM_outstall), 32'd1);
                chk("dreq_wait", 32'(MEM_outdreq), 32'd1);
                chk("memwb_rw_wait", 32'(MEM_outMEMWBREGWRITE), 32'd0);
                @(posedge clk);
                @(negedge clk);
                #1;
            end
            MEM_indready = 1'b1;
            MEM_indrdata = o.rdata;
        end else begin
            MEM_indready = 1'($urandom_range(0, 1));
            MEM_indrdata = $urandom;
        end
        #1;
        chk("stall_done", 32'(MEM_outstall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        MEM_indready = 1'b0;
        #1;
        chk("misalign_off", 32'(MEM_outmisalign), 32'd0);
        chk("memwb_rw", 32'(MEM_outMEMWBREGWRITE), 32'(e.wb_rw));
        if (e.wb_rw) begin
            chk("memwb_rd", 32'(MEM_outMEMWBREGISTERRDRT), 32'(o.regdst));
            chk("memwb_data", MEM_outfromMEMWB, e.wb_data);
        end
    endtask

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        op_t o, b;
        tbl[0] = '{'{1'b1, 32'h0000_0005, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0},
                   '{1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0005}};
        tbl[1] = '{'{1'b1, 32'h0000_0103, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 2, 32'h80FF_FF00},
                   '{1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 32'hFFFF_FF80}};
        tbl[2] = '{'{1'b1, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 0, 32'h0},
                   '{1'b0, 32'h0000_0102, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h100, 32'hABCD_ABCD, 1'b0, 32'h0}};
        tbl[3] = '{'{1'b1, 32'h0000_0101, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 32'h0},
                   '{1'b0, 32'h0000_0101, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0}};
        tbl[4] = '{'{1'b1, 32'h0000_1234, 32'h0, 32'h0040_0010, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0},
                   '{1'b1, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0010}};
        tbl[5] = '{'{1'b1, 32'h0000_0007, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0},
                   '{1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0}};
        tbl[6] = '{'{1'b1, 32'h0000_0202, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1, 32'h8765_4321},
                   '{1'b1, 32'h0000_0202, 1'b1, 1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 1'b1, 32'h0000_8765}};
        tbl[7] = '{'{1'b0, 32'h0000_0300, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 32'h0},
                   '{1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0}};

        reset = 1'b1;
        drive(bubble());
        MEM_indready = 1'b0;
        MEM_indrdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_dreq", 32'(MEM_outdreq), 32'd0);
        chk("rst_stall", 32'(MEM_outstall), 32'd0);
        chk("rst_misalign", 32'(MEM_outmisalign), 32'd0);
        chk("rst_exmem_rw", 32'(MEM_outEXMEMREGWRITE), 32'd0);
        chk("rst_exmem_data", MEM_outfromEXMEM, 32'd0);
        chk("rst_memwb_rw", 32'(MEM_outMEMWBREGWRITE), 32'd0);
        chk("rst_memwb_data", MEM_outfromMEMWB, 32'd0);

        for (int i = 0; i < 8; i++) apply(tbl[i].op, tbl[i].e);

        for (int i = 0; i < 150; i++) begin
            int kind;
            kind       = $urandom_range(0, 2);
            o.valid    = ($urandom_range(0, 7) != 0);
            o.answer   = $urandom;
            o.sdata    = $urandom;
            o.pc8      = $urandom;
            o.regdst   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            o.andlink  = (kind == 0) && ($urandom_range(0, 4) == 0);
            o.regwrite = (kind != 2) && ($urandom_range(0, 5) != 0);
            o.memread  = (kind == 1);
            o.memwrite = (kind == 2);
            o.size     = 2'($urandom);
            o.sign     = 1'($urandom);
            o.waitn    = $urandom_range(0, 3);
            o.rdata    = $urandom;
            apply(o, model(o));
        end

        // EX inputs presented during a stall are taken only on the ready edge
        o = bubble();
        o.valid = 1'b1; o.answer = 32'h300; o.regdst = 5'd8; o.regwrite = 1'b1; o.memread = 1'b1;
        b = bubble();
        b.valid = 1'b1; b.answer = 32'h55; b.regdst = 5'd9; b.regwrite = 1'b1;
        @(negedge clk);
        drive(o);
        @(posedge clk);
        @(negedge clk);
        drive(b);
        #1;
        chk("hold_stall0", 32'(MEM_outstall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("hold_exmem", MEM_outfromEXMEM, 32'h300);
        chk("hold_stall1", 32'(MEM_outstall), 32'd1);
        MEM_indready = 1'b1;
        MEM_indrdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        drive(bubble());
        MEM_indready = 1'b0;
        #1;
        chk("hold_next_exmem", MEM_outfromEXMEM, 32'h55);
        chk("hold_next_rd", 32'(MEM_outEXMEMREGISTERRDRT), 32'd9);
        chk("hold_wb_data", MEM_outfromMEMWB, 32'hCAFE_F00D);
        chk("hold_wb_rd", 32'(MEM_outMEMWBREGISTERRDRT), 32'd8);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("hold_wb_next", MEM_outfromMEMWB, 32'h55);
        chk("hold_wb_next_rw", 32'(MEM_outMEMWBREGWRITE), 32'd1);

        // reset while waiting abandons the access
        o = bubble();
        o.valid = 1'b1; o.answer = 32'h400; o.regdst = 5'd10; o.regwrite = 1'b1; o.memread = 1'b1;
        @(negedge clk);
        drive(o);
        @(posedge clk);
        @(negedge clk);
        drive(bubble());
        #1;
        chk("rw_stall", 32'(MEM_outstall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_dreq", 32'(MEM_outdreq), 32'd0);
        chk("rw_stall_off", 32'(MEM_outstall), 32'd0);
        chk("rw_exmem_rw", 32'(MEM_outEXMEMREGWRITE), 32'd0);
        chk("rw_memwb_rw", 32'(MEM_outMEMWBREGWRITE), 32'd0);
        MEM_indready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MEM_indready = 1'b0;
        #1;
        chk("rw_memwb_after", 32'(MEM_outMEMWBREGWRITE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
